// File: rtl/voq_out_arbiter_pkg.sv
// Shared definitions for the VOQ output arbiter.
//   - Default port count and payload width (overridable from the command line).
//   - FSM state type of the arbiter.
//   - Position of the eop bit inside a VOQ head word {eop, data}.
`ifndef PORT_NUB_TOTAL
`define PORT_NUB_TOTAL 4
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package voq_out_arbiter_pkg;

  localparam int PORT_NUB_TOTAL = `PORT_NUB_TOTAL;
  localparam int DATA_WIDTH_DEF = `DATA_WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arb_state_t;

  // A VOQ head word is {eop, data}; eop sits just above the payload.
  localparam int VOQ_EOP_BIT_DEF = DATA_WIDTH_DEF;

  function automatic int voq_eop_bit(input int data_width);
    return data_width;
  endfunction

endpackage

// File: rtl/voq_out_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req  : request vector, one bit per VOQ
//   base : index where the upward scan starts (wraps modulo PORT_NUB)
//   any  : at least one request is set
//   pick : first requesting index at or after base
module rr_pick
  import voq_out_arbiter_pkg::*;
#(
  parameter int PORT_NUB  = PORT_NUB_TOTAL,
  parameter int WIDTH_SEL = $clog2(PORT_NUB)
) (
  input  logic [PORT_NUB-1:0]  req,
  input  logic [WIDTH_SEL-1:0] base,
  output logic                 any,
  output logic [WIDTH_SEL-1:0] pick
);

  int                   idx;
  logic [WIDTH_SEL-1:0] idx_s;

  // Scan from the farthest offset down to offset 0 so the closest
  // requester to base is the last (and therefore winning) assignment.
  always_comb begin
    any   = 1'b0;
    pick  = '0;
    idx   = 0;
    idx_s = '0;
    for (int k = PORT_NUB - 1; k >= 0; k--) begin
      idx   = (int'(base) + k) % PORT_NUB;
      idx_s = idx[WIDTH_SEL-1:0];
      if (req[idx_s]) begin
        any  = 1'b1;
        pick = idx_s;
      end
    end
  end

endmodule

// File: rtl/voq_out_arbiter.sv
// Output-port arbiter for the VOQ read side. Selects one non-empty VOQ with
// packet-granular round-robin and drains it word by word into a registered
// output stage; each word is tagged with its source port number.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_in     : per-VOQ non-empty flag (head word valid)
//   head_in    : per-VOQ head word, slice i = {eop, data}
//   rd_en_out  : one-hot pop strobe to the VOQs (combinational)
//   ready_in   : downstream accepts data_out this cycle
//   valid_out  : output word valid (registered)
//   data_out   : {src_port, data} (registered)
//   eop_out    : last word of the packet (registered)
//   done_out   : one-cycle pulse on bit i after the eop word of VOQ i is popped
//   busy_out   : FSM is in SEND (exposes the FSM state)
//
// Handshake: a word moves downstream on every cycle where valid_out && ready_in.
// The output register accepts a new word when it is empty or being drained
// (!valid_out || ready_in); otherwise it holds data_out/eop_out unchanged.
module voq_out_arbiter
  import voq_out_arbiter_pkg::*;
#(
  parameter int PORT_NUB   = `PORT_NUB_TOTAL,
  parameter int DATA_WIDTH = `DATA_WIDTH,
  parameter int WIDTH_SEL  = $clog2(PORT_NUB),
  parameter int WIDTH_PORT = WIDTH_SEL + DATA_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [PORT_NUB-1:0]              req_in,
  input  logic [PORT_NUB*(DATA_WIDTH+1)-1:0] head_in,
  output logic [PORT_NUB-1:0]              rd_en_out,
  input  logic                             ready_in,
  output logic                             valid_out,
  output logic [WIDTH_PORT-1:0]            data_out,
  output logic                             eop_out,
  output logic [PORT_NUB-1:0]              done_out,
  output logic                             busy_out
);

  localparam int EOP_BIT = voq_eop_bit(DATA_WIDTH);

  arb_state_t           state;
  logic [WIDTH_SEL-1:0] grant;
  logic [WIDTH_SEL-1:0] last_grant;
  logic [WIDTH_SEL-1:0] base;
  logic [WIDTH_SEL-1:0] pick;
  logic                 any;
  logic [PORT_NUB-1:0]  grant_oh;
  logic [DATA_WIDTH:0]  head_sel;
  logic                 req_sel;
  logic                 pop;

  // Scan starts one past the last served port, wrapping to 0.
  assign base = (last_grant == WIDTH_SEL'(PORT_NUB - 1)) ? '0
                                                         : last_grant + WIDTH_SEL'(1);

  rr_pick #(
    .PORT_NUB  (PORT_NUB),
    .WIDTH_SEL (WIDTH_SEL)
  ) u_rr_pick (
    .req  (req_in),
    .base (base),
    .any  (any),
    .pick (pick)
  );

  always_comb begin
    grant_oh = '0;
    head_sel = '0;
    for (int i = 0; i < PORT_NUB; i++) begin
      if (grant == WIDTH_SEL'(i)) begin
        grant_oh[i] = 1'b1;
        head_sel    = head_in[i*(DATA_WIDTH+1) +: (DATA_WIDTH+1)];
      end
    end
  end

  assign req_sel = |(req_in & grant_oh);

  // Only the granted VOQ can pop; a stalled output register blocks it, and an
  // empty granted VOQ (underflow) simply waits without re-arbitrating.
  assign pop       = (state == ST_SEND) && req_sel && (!valid_out || ready_in);
  assign rd_en_out = pop ? grant_oh : '0;
  assign busy_out  = (state == ST_SEND);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      grant      <= '0;
      last_grant <= WIDTH_SEL'(PORT_NUB - 1);
      valid_out  <= 1'b0;
      data_out   <= '0;
      eop_out    <= 1'b0;
      done_out   <= '0;
    end else begin
      done_out <= '0;

      if (pop) begin
        valid_out <= 1'b1;
        data_out  <= {grant, head_sel[DATA_WIDTH-1:0]};
        eop_out   <= head_sel[EOP_BIT];
      end else if (ready_in) begin
        valid_out <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (any) begin
            grant <= pick;
            state <= ST_SEND;
          end
        end
        ST_SEND: begin
          // The grant is held until the eop word leaves the VOQ.
          if (pop && head_sel[EOP_BIT]) begin
            done_out   <= grant_oh;
            last_grant <= grant;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voq_out_arbiter.sv
// Bench for voq_out_arbiter: VOQs modelled as queues of {eop, data} words,
// expected pop order produced by a packet-level round-robin model.
module tb_voq_out_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int WS = 2;
  localparam int WP = WS + DW;
  localparam int WE = WS + DW + 1;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]        req_in;
  logic [N*(DW+1)-1:0] head_in;
  logic [N-1:0]        rd_en_out;
  logic                ready_in;
  logic                valid_out;
  logic [WP-1:0]       data_out;
  logic                eop_out;
  logic [N-1:0]        done_out;
  logic                busy_out;

  voq_out_arbiter #(
    .PORT_NUB   (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_in    (req_in),
    .head_in   (head_in),
    .rd_en_out (rd_en_out),
    .ready_in  (ready_in),
    .valid_out (valid_out),
    .data_out  (data_out),
    .eop_out   (eop_out),
    .done_out  (done_out),
    .busy_out  (busy_out)
  );

  // ---------------- bench state ----------------
  logic [DW:0]   voq[N][$];     // what the VOQs hold (drives req/head)
  logic [DW:0]   mdl_q[N][$];   // packets not yet scheduled by the model
  logic [WE-1:0] exp_q[$];      // expected pop sequence {port, eop, data}
  int            mdl_last;
  int            n_pass = 0;
  int            n_checks = 0;
  int            cyc = 0;
  bit            pend_pop;
  logic [WS-1:0] pend_port;
  logic [DW:0]   pend_word;
  logic          exp_valid;
  logic [WP-1:0] held_data;
  logic          held_eop;
  logic          prev_ready;
  bit            rand_ready;
  logic          ready_force;
  logic [N-1:0]  hold;
  int            pop_cyc[$];
  int            pop_port[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- reference model ----------------
  task automatic model_reset();
    mdl_last   = N - 1;
    exp_valid  = 1'b0;
    held_data  = '0;
    held_eop   = 1'b0;
    pend_pop   = 0;
    prev_ready = 1'b0;
  endtask

  // Packet-level round robin: next packet comes from the first non-empty
  // port after the last one served; a packet is always taken whole.
  task automatic mdl_schedule();
    bit          found;
    int          p;
    logic [DW:0] w;
    do begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        p = (mdl_last + k) % N;
        if (!found && mdl_q[p].size() > 0) begin
          found    = 1;
          mdl_last = p;
          do begin
            w = mdl_q[p].pop_front();
            exp_q.push_back({WS'(p), w});
          end while (!w[DW] && mdl_q[p].size() > 0);
        end
      end
    end while (found);
  endtask

  // ---------------- driver tasks ----------------
  task automatic load_pkt(input int p, input int len, input logic [DW-1:0] base);
    logic [DW:0] w;
    for (int i = 0; i < len; i++) begin
      w = {(i == len - 1), base + DW'(i)};
      voq[p].push_back(w);
      mdl_q[p].push_back(w);
    end
  endtask

  // One clock cycle: check registered outputs, drive inputs, observe pops.
  task automatic step();
    logic [N*(DW+1)-1:0] h;
    logic [N-1:0]        ed;
    logic [WE-1:0]       e;
    logic [DW:0]         w;
    int                  p;
    int                  ones;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rd_en_in_reset", rd_en_out, '0);
      pend_pop   = 0;
      prev_ready = 1'b0;
    end else begin
      if (pend_pop) begin
        exp_valid = 1'b1;
        held_data = {pend_port, pend_word[DW-1:0]};
        held_eop  = pend_word[DW];
        ed = '0;
        if (pend_word[DW]) ed[pend_port] = 1'b1;
        chk("done_out", done_out, ed);
      end else begin
        if (prev_ready) exp_valid = 1'b0;
        chk("done_quiet", done_out, '0);
      end
      chk("valid_out", valid_out, exp_valid);
      chk("data_out", data_out, held_data);
      chk("eop_out", eop_out, held_eop);
    end

    ready_in = rand_ready ? ($urandom_range(0, 3) != 0) : ready_force;
    h = '0;
    for (int i = 0; i < N; i++) begin
      req_in[i] = (voq[i].size() > 0) && !hold[i];
      if (voq[i].size() > 0) h[i*(DW+1) +: (DW+1)] = voq[i][0];
    end
    head_in = h;
    #1;

    pend_pop = 0;
    if (rst_n && rd_en_out != '0) begin
      ones = 0;
      p = 0;
      for (int i = 0; i < N; i++) if (rd_en_out[i]) begin ones++; p = i; end
      chk("rd_en_onehot", ones, 1);
      chk("rd_en_req", req_in[p], 1'b1);
      chk("pop_in_stall", valid_out && !ready_in, 1'b0);
      if (voq[p].size() > 0) begin
        w = voq[p].pop_front();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 'x;
        chk("pop_order", {WS'(p), w}, e);
        pend_pop  = 1;
        pend_port = WS'(p);
        pend_word = w;
        pop_cyc.push_back(cyc);
        pop_port.push_back(p);
      end
    end
    prev_ready = ready_in;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_rd_en", rd_en_out, '0);
    chk("rst_valid", valid_out, 1'b0);
    chk("rst_data", data_out, '0);
    chk("rst_eop", eop_out, 1'b0);
    chk("rst_done", done_out, '0);
    chk("rst_busy", busy_out, 1'b0);
    for (int i = 0; i < N; i++) begin
      voq[i].delete();
      mdl_q[i].delete();
    end
    exp_q.delete();
    model_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((exp_q.size() > 0 || pend_pop) && n < max) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    exp_q.delete();
    step();
  endtask

  task automatic wait_pops(input int cnt);
    int g = 0;
    while (pop_port.size() < cnt && g < 50) begin
      step();
      g++;
    end
    chk("wait_pops", pop_port.size() >= cnt, 1'b1);
  endtask

  task automatic clear_log();
    pop_cyc.delete();
    pop_port.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int t_req;
    int fair_exp[6];
    req_in      = '0;
    head_in     = '0;
    ready_in    = 1'b1;
    rand_ready  = 0;
    ready_force = 1'b1;
    hold        = '0;
    model_reset();
    #2;
    do_reset();
    step();

    // First request: 3-word packet on VOQ 2.
    clear_log();
    load_pkt(2, 3, 8'hA1);
    mdl_schedule();
    t_req = cyc + 1;
    drain(40);
    chk("t1_pops", pop_port.size(), 3);
    if (pop_port.size() == 3)
      for (int i = 0; i < 3; i++) begin
        chk("t1_port", pop_port[i], 2);
        chk("t1_cycle", pop_cyc[i], t_req + 1 + i);
      end

    // Round-robin fairness from reset priority.
    do_reset();
    clear_log();
    load_pkt(0, 1, 8'h10);
    load_pkt(1, 1, 8'h20);
    load_pkt(3, 1, 8'h30);
    load_pkt(0, 1, 8'h11);
    load_pkt(1, 1, 8'h21);
    load_pkt(3, 1, 8'h31);
    mdl_schedule();
    drain(60);
    fair_exp = '{0, 1, 3, 0, 1, 3};
    chk("fair_pops", pop_port.size(), 6);
    if (pop_port.size() == 6)
      for (int i = 0; i < 6; i++) begin
        chk("fair_order", pop_port[i], fair_exp[i]);
        if (i > 0) chk("fair_gap", pop_cyc[i] - pop_cyc[i-1], 2);
      end

    // Wrap-around: last served port is 3.
    clear_log();
    load_pkt(3, 2, 8'h50);
    load_pkt(1, 2, 8'h40);
    mdl_schedule();
    drain(60);
    chk("wrap_pops", pop_port.size(), 4);
    if (pop_port.size() == 4) begin
      chk("wrap_first", pop_port[0], 1);
      chk("wrap_second", pop_port[2], 3);
    end

    // No interleave: VOQ 1 requests while VOQ 0 is mid-packet.
    clear_log();
    load_pkt(0, 4, 8'h60);
    mdl_schedule();
    wait_pops(2);
    load_pkt(1, 2, 8'h70);
    mdl_schedule();
    drain(60);
    chk("nil_pops", pop_port.size(), 6);
    if (pop_port.size() == 6) begin
      for (int i = 0; i < 4; i++) chk("nil_port0", pop_port[i], 0);
      chk("nil_port1", pop_port[4], 1);
    end

    // Backpressure for 3 cycles mid-packet.
    clear_log();
    load_pkt(2, 5, 8'h80);
    mdl_schedule();
    wait_pops(2);
    ready_force = 1'b0;
    repeat (3) begin
      step();
      chk("bp_rd_en", rd_en_out, '0);
      chk("bp_data", data_out, {2'd2, 8'h81});
    end
    ready_force = 1'b1;
    drain(60);
    chk("bp_pops", pop_port.size(), 5);

    // Randomized traffic with random backpressure.
    rand_ready = 1;
    for (int ph = 0; ph < 6; ph++) begin
      repeat ($urandom_range(1, 6))
        load_pkt($urandom_range(0, N - 1), $urandom_range(1, 4), DW'($urandom));
      mdl_schedule();
      drain(500);
    end
    rand_ready = 0;

    // Underflow mid-packet, then reset.
    clear_log();
    load_pkt(1, 3, 8'hB1);
    mdl_schedule();
    wait_pops(1);
    hold[1] = 1'b1;
    repeat (4) begin
      step();
      chk("uf_busy", busy_out, 1'b1);
      chk("uf_rd_en", rd_en_out, '0);
    end
    do_reset();
    hold = '0;
    clear_log();
    load_pkt(3, 1, 8'hD0);
    load_pkt(0, 1, 8'hC0);
    mdl_schedule();
    drain(40);
    chk("post_rst_pops", pop_port.size(), 2);
    if (pop_port.size() == 2) chk("post_rst_first", pop_port[0], 0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voq_out_arbiter.md
# voq_out_arbiter

Read-side counterpart of the VOQ write chain: one instance per output port. It watches the `PORT_NUB` virtual output queues that hold packets for its port, selects one with packet-granular round-robin, and drains it word by word into a registered output stage. Each output word is tagged with the source port number. The block sits between the shared-memory VOQ FIFOs (first-word-fall-through) and the output port transmitter.

## Interface
Parameters:
- `PORT_NUB`, default `` `PORT_NUB_TOTAL ``: number of input ports, and therefore the number of VOQs feeding this output.
- `DATA_WIDTH`, default `` `DATA_WIDTH ``: payload word width.
- `WIDTH_SEL`, default `$clog2(PORT_NUB)`: width of a port number.
- `WIDTH_PORT`, default `WIDTH_SEL+DATA_WIDTH`: width of a tagged output word.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_in` in `PORT_NUB`: bit i is high when VOQ i (input i → this output) is non-empty, meaning its head word is valid.
- `head_in` in `PORT_NUB*(DATA_WIDTH+1)`: head word of each VOQ. Slice i is `{eop, data}`.
- `rd_en_out` out `PORT_NUB`: one-hot pop strobe to the VOQs; combinational.
- `ready_in` in 1: downstream accepts `data_out` this cycle.
- `valid_out` out 1: output word valid; registered.
- `data_out` out `WIDTH_PORT`: `{src_nub, data}`; registered.
- `eop_out` out 1: last word of the packet; registered.
- `done_out` out `PORT_NUB`: one-cycle pulse on bit i when the eop word of VOQ i is popped; registered.
- `busy_out` out 1: high while in SEND.

## Operation
- State machine, 2 states.
- **IDLE**
  - If `|req_in`, the grant is the first set bit scanning upward from `last_grant+1`, wrapping modulo `PORT_NUB`.
  - Register the result in `grant` and go to SEND.
  - No pop happens in IDLE.
- **SEND** — a pop is defined as `pop = req_in[grant] && (!valid_out || ready_in)`.
  - On a pop:
    - `rd_en_out[grant]=1`.
    - The output register loads `{grant, head_in[grant].data}` and `eop_out` loads the head word's eop bit.
    - `valid_out` goes to 1.
  - If the popped word has eop=1:
    - `done_out[grant]` pulses the next cycle.
    - `last_grant <= grant`.
    - The FSM returns to IDLE.
  - If `ready_in` is high and there is no pop, `valid_out` goes to 0.
- Output register rule: it holds its value while `valid_out && !ready_in`, and never changes under stall.
- At most one `rd_en_out` bit is high in any cycle, and only the granted index.
- Packets are never interleaved. A grant is held until its eop word is popped, regardless of other requests.
- Underflow mid-packet: if `req_in[grant]` drops before eop, the block waits in SEND with no pop and no timeout; it does not re-arbitrate.
- Requests on non-granted ports have no effect until the FSM is back in IDLE.

## Timing
- Reset values:
  - FSM = IDLE, `grant=0`, `last_grant=PORT_NUB-1`, so port 0 has first priority.
  - `valid_out=0`, `data_out=0`, `eop_out=0`, `done_out=0`, `busy_out=0`.
  - `rd_en_out=0`.
- Reset asserted mid-packet: all of the above happen immediately. Any partially drained packet stays in the VOQ from its next word onward; the block does not attempt to resynchronise it.
- Latency:
  - `req_in` rises in cycle N (FSM in IDLE).
  - `grant` is registered at the edge ending N, and `rd_en_out` is high in N+1.
  - `valid_out` is high in N+2.
- Throughput:
  - With `ready_in` held high and the VOQ supplying data, a packet of L words pops in L consecutive cycles.
  - Between packets there is exactly one IDLE arbitration cycle.
- Stall: `ready_in=0` with `valid_out=1` means no pop and `rd_en_out=0`; data is held.
- Single-word packet (eop on the first word): one pop, then IDLE in the next cycle.
- Wrap-around: with `last_grant=PORT_NUB-1`, the scan starts at 0.

## Structure
- Shared package / header `generate_parameter.vh` provides `` `PORT_NUB_TOTAL `` and `` `DATA_WIDTH ``.
- Add to the package: a VOQ head-word eop bit index constant.
- Sub-module `rr_pick`: purely combinational round-robin picker.
  - Inputs: `req` [PORT_NUB] and `base` [WIDTH_SEL].
  - Outputs: `any`, and the index `pick`.
- The FSM, the output register and the done logic live in the top.

## Test plan
- **Reset / first request:** `PORT_NUB=4`; VOQ 2 holds a 3-word packet 0xA1, 0xA2, 0xA3(eop); `ready_in=1`.
  - `rd_en_out[2]` is high on 3 consecutive cycles.
  - Outputs are `data_out={2,0xA1}`, `{2,0xA2}`, `{2,0xA3}` with `eop_out` on the third.
  - `done_out=4'b0100` for one cycle.
- **Round-robin fairness:** VOQs 0, 1 and 3 each hold two 1-word packets.
  - Service order: 0, 1, 3, 0, 1, 3.
  - Exactly one idle cycle between packets.
- **Wrap-around:** `last_grant=3`; VOQs 1 and 3 are requesting.
  - Next grant is 1, then 3.
- **No interleave:** VOQ 0 is sending a 4-word packet; VOQ 1 raises `req` at word 2.
  - All 4 words of port 0 are output before any port-1 word.
- **Backpressure:** `ready_in` is held low for 3 cycles mid-packet.
  - `data_out` is stable throughout, `rd_en_out=0`, and no words are lost or duplicated.
- **Underflow and reset:** `req_in[grant]` drops after word 1, then `rst_n` is pulsed low.
  - While `req_in[grant]` is low: FSM in SEND, no pops.
  - After reset: all outputs 0, and the next arbitration starts from port 0.
